lock_access_controller: RTL and testbench

- Sequencing controller for the hex-keypad password lock.
- Takes debounced button levels (enter, set, change, clear) and a 4-bit hex digit.
- Assembles 4-digit codes, checks them against the stored password, and handles unlock and relock.
- Runs a two-entry password change (new code, then confirm) and enforces a timed lockout after repeated failures. It owns the password register seen by the display logic.

---
 rtl/lock_access_controller_if.sv | 44 ++++
 rtl/lock_access_controller.sv | 170 +++++++++++++++++
 tb/tb_lock_access_controller.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_access_controller_if.sv
// ---------------------------------------------------------------------------
// lock_access_controller_if
//   Keypad/button inputs and lock status outputs of the password lock
//   sequencing controller.
//
//   master : keypad/debounce side (drives buttons and digit, reads status)
//   slave  : lock_access_controller
//
//   hex_in           4  digit value, sampled on an enter press
//   enter/set/change/clear  debounced, clk-synchronous button levels
//   current_password 16 stored password
//   state            3  0 LOCKED, 1 UNLOCKED, 2 CHG_NEW, 3 CHG_CONFIRM, 4 LOCKOUT
//   digit_count      3  digits collected in the current entry (0..3)
//   entry_buf        16 digits shifted in so far
//   fail_count       3  consecutive unlock mismatches
//   ok_pulse         1  one-cycle success strobe
//   err_pulse        1  one-cycle failure strobe
// ---------------------------------------------------------------------------
interface lock_access_controller_if;
    logic [3:0]  hex_in;
    logic        enter;
    logic        set;
    logic        change;
    logic        clear;
    logic [15:0] current_password;
    logic [2:0]  state;
    logic [2:0]  digit_count;
    logic [15:0] entry_buf;
    logic [2:0]  fail_count;
    logic        ok_pulse;
    logic        err_pulse;

    modport master (
        output hex_in, enter, set, change, clear,
        input  current_password, state, digit_count, entry_buf,
               fail_count, ok_pulse, err_pulse
    );

    modport slave (
        input  hex_in, enter, set, change, clear,
        output current_password, state, digit_count, entry_buf,
               fail_count, ok_pulse, err_pulse
    );
endinterface

// File: rtl/lock_access_controller.sv
// ---------------------------------------------------------------------------
// lock_access_controller
//   Sequencing controller for the hex-keypad password lock. Detects button
//   presses (rising levels), assembles 4-digit codes, checks them against
//   the stored password, runs the two-entry password change and enforces a
//   timed lockout after MAX_FAILS consecutive unlock mismatches.
//
//   clk    : system clock, all logic on the rising edge
//   reset  : asynchronous, active-high; returns everything to reset values
//   bus    : lock_access_controller_if.slave (buttons in, status out)
//
//   Parameters:
//     DEFAULT_PW     password loaded on reset
//     MAX_FAILS      consecutive mismatches that trigger lockout (1..7)
//     LOCKOUT_CYCLES clk cycles spent in LOCKOUT (>= 2)
// ---------------------------------------------------------------------------
module lock_access_controller #(
    parameter logic [15:0] DEFAULT_PW     = 16'h0000,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 100_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    lock_access_controller_if.slave   bus
);

    localparam int TIMER_W = $clog2(LOCKOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_LOCKED      = 3'd0,
        ST_UNLOCKED    = 3'd1,
        ST_CHG_NEW     = 3'd2,
        ST_CHG_CONFIRM = 3'd3,
        ST_LOCKOUT     = 3'd4
    } state_t;

    state_t               st;
    logic [15:0]          password;
    logic [15:0]          pending;
    logic [15:0]          buf_q;
    logic [2:0]           count_q;
    logic [2:0]           fails_q;
    logic [TIMER_W-1:0]   timer;
    logic                 ok_q;
    logic                 err_q;

    // Previous button samples for rising-level press detection.
    logic enter_d, set_d, change_d, clear_d;

    logic        enter_press, set_press, change_press, clear_press;
    logic [15:0] code;
    logic [2:0]  fails_next;
    logic        last_digit;

    assign enter_press  = bus.enter  & ~enter_d;
    assign set_press    = bus.set    & ~set_d;
    assign change_press = bus.change & ~change_d;
    assign clear_press  = bus.clear  & ~clear_d;

    // Buffer contents including the digit being entered this cycle; on the
    // fourth digit this is the completed code.
    assign code       = {buf_q[11:0], bus.hex_in};
    assign last_digit = (count_q == 3'd3);
    assign fails_next = fails_q + 3'd1;

    // NOTE: all state is updated with non-blocking assignments so every
    // decision in this block sees the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= ST_LOCKED;
            password <= DEFAULT_PW;
            pending  <= '0;
            buf_q    <= '0;
            count_q  <= '0;
            fails_q  <= '0;
            timer    <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            enter_d  <= 1'b0;
            set_d    <= 1'b0;
            change_d <= 1'b0;
            clear_d  <= 1'b0;
        end else begin
            enter_d  <= bus.enter;
            set_d    <= bus.set;
            change_d <= bus.change;
            clear_d  <= bus.clear;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;

            // One action per cycle, chosen by priority clear > set > change
            // > enter; lower-priority presses in the same cycle are lost.
            if (st == ST_LOCKOUT) begin
                if (timer == '0) begin
                    st      <= ST_LOCKED;
                    fails_q <= '0;
                end else begin
                    timer <= timer - 1'b1;
                end
            end else if (clear_press) begin
                buf_q   <= '0;
                count_q <= '0;
                if (st == ST_CHG_CONFIRM) begin
                    st      <= ST_CHG_NEW;
                    pending <= '0;
                end
            end else if (set_press) begin
                // Relock from any open state; aborts a change in progress.
                if (st != ST_LOCKED) begin
                    st      <= ST_LOCKED;
                    buf_q   <= '0;
                    count_q <= '0;
                end
            end else if (change_press) begin
                if (st == ST_UNLOCKED)
                    st <= ST_CHG_NEW;
            end else if (enter_press && st != ST_UNLOCKED) begin
                if (!last_digit) begin
                    buf_q   <= code;
                    count_q <= count_q + 3'd1;
                end else begin
                    buf_q   <= '0;
                    count_q <= '0;
                    case (st)
                        ST_LOCKED: begin
                            if (code == password) begin
                                st      <= ST_UNLOCKED;
                                fails_q <= '0;
                                ok_q    <= 1'b1;
                            end else begin
                                err_q   <= 1'b1;
                                fails_q <= fails_next;
                                if (fails_next == 3'(MAX_FAILS)) begin
                                    st    <= ST_LOCKOUT;
                                    // Counts down to zero; the exit happens
                                    // on the edge that sees zero, giving
                                    // exactly LOCKOUT_CYCLES cycles here.
                                    timer <= TIMER_W'(LOCKOUT_CYCLES - 1);
                                end
                            end
                        end
                        ST_CHG_NEW: begin
                            pending <= code;
                            st      <= ST_CHG_CONFIRM;
                        end
                        ST_CHG_CONFIRM: begin
                            if (code == pending) begin
                                password <= pending;
                                ok_q     <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            st <= ST_UNLOCKED;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.current_password = password;
    assign bus.state            = st;
    assign bus.digit_count      = count_q;
    assign bus.entry_buf        = buf_q;
    assign bus.fail_count       = fails_q;
    assign bus.ok_pulse         = ok_q;
    assign bus.err_pulse        = err_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// ---------------------------------------------------------------------------
// tb_lock_access_controller
//   Directed walk through the lock scenarios followed by random button
//   traffic. A reference model (digit queue, integer mode, cycle-stamped
//   lockout deadline) predicts the lock status; predicted ok/err strobes
//   are queued and matched by an independent monitor.
// ---------------------------------------------------------------------------
module tb_lock_access_controller;

    localparam int LOCK_CYC  = 20;
    localparam int MAX_F     = 3;
    localparam logic [15:0] DEF_PW = 16'h0000;

    // Button vector order used throughout: {clear, set, change, enter}
    localparam logic [3:0] B_ENTER  = 4'b0001;
    localparam logic [3:0] B_CHANGE = 4'b0010;
    localparam logic [3:0] B_SET    = 4'b0100;
    localparam logic [3:0] B_CLEAR  = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    lock_access_controller_if bus ();

    lock_access_controller #(
        .DEFAULT_PW     (DEF_PW),
        .MAX_FAILS      (MAX_F),
        .LOCKOUT_CYCLES (LOCK_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // modes: 0 LOCKED, 1 UNLOCKED, 2 CHG_NEW, 3 CHG_CONFIRM, 4 LOCKOUT
    int          m_mode;
    logic [15:0] m_pw;
    logic [15:0] m_pending;
    int          m_fails;
    logic [3:0]  m_digits[$];
    int          m_lock_end;

    typedef struct {
        bit          ok;
        logic [2:0]  st;
        logic [15:0] pw;
        logic [2:0]  fails;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic void model_reset();
        m_mode     = 0;
        m_pw       = DEF_PW;
        m_pending  = '0;
        m_fails    = 0;
        m_lock_end = 0;
        m_digits.delete();
        sb_q.delete();
    endfunction

    function automatic logic [15:0] model_buf();
        logic [15:0] b = '0;
        foreach (m_digits[i]) b = (b << 4) | 16'(m_digits[i]);
        return b;
    endfunction

    // Lockout expires once LOCK_CYC edges have passed since the entry edge.
    function automatic void model_refresh(input int edge_n);
        if (m_mode == 4 && edge_n >= m_lock_end) begin
            m_mode  = 0;
            m_fails = 0;
        end
    endfunction

    function automatic void push_exp(input bit ok);
        exp_t e;
        e.ok    = ok;
        e.st    = 3'(m_mode);
        e.pw    = m_pw;
        e.fails = 3'(m_fails);
        sb_q.push_back(e);
    endfunction

    function automatic void model_apply(input logic [3:0] btns,
                                        input logic [3:0] hex,
                                        input int edge_n);
        logic [15:0] code;
        model_refresh(edge_n);
        if (m_mode == 4) return;
        if (btns[3]) begin
            m_digits.delete();
            if (m_mode == 3) m_mode = 2;
        end else if (btns[2]) begin
            if (m_mode != 0) begin
                m_mode = 0;
                m_digits.delete();
            end
        end else if (btns[1]) begin
            if (m_mode == 1) m_mode = 2;
        end else if (btns[0] && m_mode != 1) begin
            m_digits.push_back(hex);
            if (m_digits.size() == 4) begin
                code = model_buf();
                m_digits.delete();
                if (m_mode == 0) begin
                    if (code == m_pw) begin
                        m_mode  = 1;
                        m_fails = 0;
                        push_exp(1'b1);
                    end else begin
                        m_fails++;
                        if (m_fails == MAX_F) begin
                            m_mode     = 4;
                            m_lock_end = edge_n + LOCK_CYC;
                        end
                        push_exp(1'b0);
                    end
                end else if (m_mode == 2) begin
                    m_pending = code;
                    m_mode    = 3;
                end else begin
                    m_mode = 1;
                    if (code == m_pending) begin
                        m_pw = code;
                        push_exp(1'b1);
                    end else begin
                        push_exp(1'b0);
                    end
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] btns, input logic [3:0] hex);
        bus.hex_in = hex;
        bus.clear  = btns[3];
        bus.set    = btns[2];
        bus.change = btns[1];
        bus.enter  = btns[0];
    endtask

    task automatic check_outputs(input string tag);
        model_refresh(cyc);
        check({tag, ".state"},    32'(bus.state),            32'(m_mode));
        check({tag, ".count"},    32'(bus.digit_count),      32'(m_digits.size()));
        check({tag, ".buf"},      32'(bus.entry_buf),        32'(model_buf()));
        check({tag, ".fails"},    32'(bus.fail_count),       32'(m_fails));
        check({tag, ".password"}, 32'(bus.current_password), 32'(m_pw));
    endtask

    // Drive the buttons for 'hold' cycles, release for one, then compare.
    task automatic press(input string tag, input logic [3:0] btns,
                         input logic [3:0] hex, input int hold);
        @(negedge clk);
        drive(btns, hex);
        model_apply(btns, hex, cyc + 1);
        repeat (hold) @(negedge clk);
        drive(4'b0000, hex);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic enter_code(input string tag, input logic [15:0] c);
        for (int i = 3; i >= 0; i--)
            press(tag, B_ENTER, c[i*4 +: 4], 1);
    endtask

    // ---------------- pulse monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (bus.ok_pulse || bus.err_pulse)) begin
                check("pulse_exclusive", 32'(bus.ok_pulse & bus.err_pulse), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pulse_unexpected: got ok=%0b err=%0b expected none (cycle %0d)",
                             bus.ok_pulse, bus.err_pulse, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse.ok",       32'(bus.ok_pulse),         32'(e.ok));
                    check("pulse.err",      32'(bus.err_pulse),        32'(!e.ok));
                    check("pulse.state",    32'(bus.state),            32'(e.st));
                    check("pulse.password", 32'(bus.current_password), 32'(e.pw));
                    check("pulse.fails",    32'(bus.fail_count),       32'(e.fails));
                end
            end
        end
    end

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] btns;
        logic [3:0] hex;
        int r;
        int guard;

        reset = 1'b1;
        drive(4'b0000, 4'h0);
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.state",    32'(bus.state),            32'd0);
        check("reset.password", 32'(bus.current_password), 32'(DEF_PW));
        check("reset.count",    32'(bus.digit_count),      32'd0);
        check("reset.buf",      32'(bus.entry_buf),        32'd0);
        check("reset.fails",    32'(bus.fail_count),       32'd0);
        check("reset.pulses",   32'({bus.ok_pulse, bus.err_pulse}), 32'd0);
        reset = 1'b0;

        // Unlock with the default password.
        enter_code("unlock0", 16'h0000);
        check("unlock0.state_is_1", 32'(bus.state), 32'd1);

        // Change password to FFFF, then relock.
        press("chg", B_CHANGE, 4'h0, 1);
        enter_code("chg_new", 16'hFFFF);
        check("chg_new.state_is_3", 32'(bus.state), 32'd3);
        enter_code("chg_conf", 16'hFFFF);
        check("chg_conf.pw_ffff", 32'(bus.current_password), 32'hFFFF);
        press("relock", B_SET, 4'h0, 1);

        // Three failures -> lockout.
        for (int k = 0; k < 3; k++) enter_code("fail", 16'hAAAA);
        check("lockout.state_is_4", 32'(bus.state), 32'd4);
        press("lk_enter", B_ENTER, 4'hF, 1);
        press("lk_clear", B_CLEAR, 4'hF, 1);
        press("lk_set",   B_SET | B_ENTER, 4'hF, 2);
        guard = 0;
        while (cyc < m_lock_end - 1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("lockout.still_at_end_minus_1", 32'(bus.state), 32'd4);
        @(negedge clk);
        check("lockout.expired_state", 32'(bus.state), 32'd0);
        check("lockout.expired_fails", 32'(bus.fail_count), 32'd0);
        check_outputs("lockout_exit");

        // Confirm mismatch leaves password unchanged.
        enter_code("unlock1", 16'hFFFF);
        press("chg2", B_CHANGE, 4'h0, 1);
        enter_code("chg2_new", 16'h5555);
        enter_code("chg2_conf", 16'h0000);
        check("chg2.pw_kept", 32'(bus.current_password), 32'hFFFF);
        press("relock2", B_SET, 4'h0, 1);

        // Partial entry, clear, clear+enter, held enter.
        press("part", B_ENTER, 4'h3, 1);
        press("part", B_ENTER, 4'h7, 1);
        press("part_clear", B_CLEAR, 4'h0, 1);
        press("part", B_ENTER, 4'h1, 1);
        press("part", B_ENTER, 4'h2, 1);
        press("clr_enter", B_CLEAR | B_ENTER, 4'h9, 1);
        check("clr_enter.count_0", 32'(bus.digit_count), 32'd0);
        press("held", B_ENTER, 4'hC, 5);
        check("held.count_1", 32'(bus.digit_count), 32'd1);
        press("held_clear", B_CLEAR, 4'h0, 1);

        // Reset in the middle of a confirm entry.
        enter_code("unlock2", 16'hFFFF);
        press("chg3", B_CHANGE, 4'h0, 1);
        enter_code("chg3_new", 16'h1234);
        press("chg3_conf", B_ENTER, 4'h1, 1);
        press("chg3_conf", B_ENTER, 4'h2, 1);
        #3 reset = 1'b1;
        #1;
        check("midreset.state",    32'(bus.state),            32'd0);
        check("midreset.count",    32'(bus.digit_count),      32'd0);
        check("midreset.password", 32'(bus.current_password), 32'(DEF_PW));
        check("midreset.pulses",   32'({bus.ok_pulse, bus.err_pulse}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if      (r < 6)  btns = B_CLEAR;
            else if (r < 12) btns = B_SET;
            else if (r < 20) btns = B_CHANGE;
            else if (r < 23) btns = B_CLEAR | B_ENTER;
            else if (r < 26) btns = B_SET | B_ENTER;
            else             btns = B_ENTER;
            hex = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                if (m_mode == 0 && m_digits.size() < 4)
                    hex = m_pw[(3 - m_digits.size()) * 4 +: 4];
                else if (m_mode == 3 && m_digits.size() < 4)
                    hex = m_pending[(3 - m_digits.size()) * 4 +: 4];
            end
            press("rand", btns, hex, $urandom_range(1, 3));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
